// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet input loader.
package maxnet_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      LAUNCH  = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int unsigned WORD_W       = 32;
   localparam int unsigned SIGN_BIT     = 31;
   localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
   localparam logic [22:0] MANT_ZERO    = 23'h0;
   localparam logic [31:0] DEFAULT_EPS  = 32'hBE4CCCCD;

endpackage

// File: rtl/maxnet_input_loader_if.sv
// Upstream word stream plus Maxnet core launch/result signals.
interface maxnet_input_loader_if;
   import maxnet_pkg::*;

   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic              start;
   logic [WORD_W-1:0] eps;
   logic [WORD_W-1:0] a1;
   logic [WORD_W-1:0] a2;
   logic [WORD_W-1:0] a3;
   logic [WORD_W-1:0] a4;
   logic              finish;
   logic              overflow;
   logic              done;
   logic [2:0]        status;

   modport slave (
      input  in_valid, in_data, finish, overflow,
      output in_ready, start, eps, a1, a2, a3, a4, done, status
   );

   modport master (
      output in_valid, in_data, finish, overflow,
      input  in_ready, start, eps, a1, a2, a3, a4, done, status
   );
endinterface

// File: rtl/maxnet_input_loader_fp_sanitize.sv
// Zeroes NaN and negative IEEE-754 singles; flags when it did so.
module fp_sanitize
   import maxnet_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   output logic [WORD_W-1:0] word_o,
   output logic              flag_o
);
   logic is_nan;
   logic is_neg;

   assign is_nan = (word_i[30:23] == EXP_ALL_ONES) && (word_i[22:0] != MANT_ZERO);
   assign is_neg = word_i[SIGN_BIT];
   assign flag_o = is_nan | is_neg;
   assign word_o = flag_o ? '0 : word_i;
endmodule

// File: rtl/maxnet_input_loader.sv
// Collects four activations, launches the Maxnet core, waits for finish or timeout.
module maxnet_input_loader
   import maxnet_pkg::*;
#(
   parameter logic [31:0] EPS_VALUE      = DEFAULT_EPS,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input logic                  clk,
   input logic                  rst,
   maxnet_input_loader_if.slave bus
);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t                   state_q, state_d;
   logic [1:0]               cnt_q, cnt_d;
   logic                     san_q, san_d;
   logic [3:0][WORD_W-1:0]   act_q, act_d;
   logic                     start_q, start_d;
   logic                     done_q, done_d;
   logic [2:0]               status_q, status_d;
   logic [31:0]              run_cnt_q, run_cnt_d;
   logic [WORD_W-1:0]        san_word;
   logic                     san_flag;
   logic                     accept;

   fp_sanitize u_sanitize (
      .word_i (bus.in_data),
      .word_o (san_word),
      .flag_o (san_flag)
   );

   assign accept = (state_q == COLLECT) && bus.in_valid;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      san_d     = san_q;
      act_d     = act_q;
      start_d   = 1'b0;
      done_d    = 1'b0;
      status_d  = status_q;
      run_cnt_d = run_cnt_q;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               act_d[cnt_q] = san_word;
               san_d        = san_q | san_flag;
               cnt_d        = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = LAUNCH;
                  start_d = 1'b1;
               end
            end
         end
         LAUNCH: begin
            state_d   = RUN;
            run_cnt_d = '0;
         end
         RUN: begin
            // finish takes priority over a coincident timeout
            if (bus.finish) begin
               done_d   = 1'b1;
               status_d = {1'b0, bus.overflow, san_q};
               san_d    = 1'b0;
               cnt_d    = '0;
               state_d  = COLLECT;
            end else if (run_cnt_q == TIMEOUT_LAST) begin
               done_d   = 1'b1;
               status_d = {1'b1, 1'b0, san_q};
               san_d    = 1'b0;
               cnt_d    = '0;
               state_d  = COLLECT;
            end else begin
               run_cnt_d = run_cnt_q + 32'd1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= COLLECT;
         cnt_q     <= '0;
         san_q     <= 1'b0;
         act_q     <= '0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= '0;
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         san_q     <= san_d;
         act_q     <= act_d;
         start_q   <= start_d;
         done_q    <= done_d;
         status_q  <= status_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   assign bus.in_ready = (state_q == COLLECT);
   assign bus.start    = start_q;
   assign bus.eps      = EPS_VALUE;
   assign bus.a1       = act_q[0];
   assign bus.a2       = act_q[1];
   assign bus.a3       = act_q[2];
   assign bus.a4       = act_q[3];
   assign bus.done     = done_q;
   assign bus.status   = status_q;
endmodule
